// File: rtl/mc_controller.sv
// Multicycle MIPS control unit: Moore FSM sequencing fetch, decode, execute,
// memory and writeback over a shared ALU and a shared handshaked memory.
module mc_controller #(
    parameter int MEM_HANDSHAKE = 1,
    parameter int ENABLE_BNE    = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic       pcen,
    output logic [2:0] alucontrol,
    output logic       illegal,
    output logic [3:0] state
);

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_EXEC   = 4'd6;
    localparam logic [3:0] S_ALUWB  = 4'd7;
    localparam logic [3:0] S_BRANCH = 4'd8;
    localparam logic [3:0] S_ADDIEX = 4'd9;
    localparam logic [3:0] S_ADDIWB = 4'd10;
    localparam logic [3:0] S_JUMP   = 4'd11;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    logic [3:0] state_q, state_d;
    logic       mem_rdy;
    logic       bne_legal;

    // With the handshake disabled every memory access completes immediately.
    assign mem_rdy   = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;
    assign bne_legal = (ENABLE_BNE != 0) && (opcode == OP_BNE);
    assign state     = state_q;

    // State register; reset returns to FETCH immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = mem_rdy ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (opcode == OP_LW || opcode == OP_SW)       state_d = S_MEMADR;
                else if (opcode == OP_RTYPE)                  state_d = S_EXEC;
                else if (opcode == OP_BEQ || bne_legal)       state_d = S_BRANCH;
                else if (opcode == OP_ADDI)                   state_d = S_ADDIEX;
                else if (opcode == OP_J)                      state_d = S_JUMP;
                else                                          state_d = S_FETCH;
            end
            S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  state_d = mem_rdy ? S_MEMWB : S_MEMRD;
            S_MEMWR:  state_d = mem_rdy ? S_FETCH : S_MEMWR;
            S_EXEC:   state_d = S_ALUWB;
            S_ADDIEX: state_d = S_ADDIWB;
            default:  state_d = S_FETCH;
        endcase
    end

    // Moore outputs per state; write/request strobes are squashed during reset.
    always_comb begin
        mem_req    = 1'b0;
        iord       = 1'b0;
        memwrite   = 1'b0;
        irwrite    = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        regwrite   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        pcen       = 1'b0;
        alucontrol = 3'b010;
        illegal    = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                alusrcb = 2'b01;
                irwrite = mem_rdy;
                pcen    = mem_rdy;
            end
            S_DECODE: begin
                alusrcb = 2'b11;
                if (!(opcode == OP_LW || opcode == OP_SW || opcode == OP_RTYPE ||
                      opcode == OP_BEQ || bne_legal || opcode == OP_ADDI ||
                      opcode == OP_J))
                    illegal = 1'b1;
            end
            S_MEMADR, S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
            end
            S_MEMWR: begin
                mem_req  = 1'b1;
                iord     = 1'b1;
                memwrite = mem_rdy;
            end
            S_MEMWB: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
            end
            S_EXEC: begin
                alusrca = 1'b1;
                case (funct)
                    6'b100000: alucontrol = 3'b010;
                    6'b100010: alucontrol = 3'b110;
                    6'b100100: alucontrol = 3'b000;
                    6'b100101: alucontrol = 3'b001;
                    6'b101010: alucontrol = 3'b111;
                    default: begin
                        alucontrol = 3'b010;
                        illegal    = 1'b1;
                    end
                endcase
            end
            S_ALUWB: begin
                regwrite = 1'b1;
                regdst   = 1'b1;
            end
            S_ADDIWB: regwrite = 1'b1;
            S_BRANCH: begin
                alusrca    = 1'b1;
                alucontrol = 3'b110;
                pcsrc      = 2'b01;
                // opcode bit 0 distinguishes bne from beq
                pcen       = opcode[0] ? !zero : zero;
            end
            S_JUMP: begin
                pcsrc = 2'b10;
                pcen  = 1'b1;
            end
            default: ;
        endcase
        if (reset) begin
            pcen     = 1'b0;
            irwrite  = 1'b0;
            regwrite = 1'b0;
            memwrite = 1'b0;
            mem_req  = 1'b0;
            illegal  = 1'b0;
        end
    end

endmodule

// File: tb/tb_mc_controller.sv
// Directed testbench for mc_controller: default build, bne-disabled build,
// and handshake-disabled build with mem_ready tied low.
module tb_mc_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode, funct;
    logic       zero, mr;
    int         tests = 0;
    int         fails = 0;

    logic       m_mem_req, m_iord, m_memwrite, m_irwrite, m_regdst, m_memtoreg, m_regwrite, m_alusrca, m_pcen, m_illegal;
    logic [1:0] m_alusrcb, m_pcsrc;
    logic [2:0] m_aluc;
    logic [3:0] m_state;

    logic       b_mem_req, b_iord, b_memwrite, b_irwrite, b_regdst, b_memtoreg, b_regwrite, b_alusrca, b_pcen, b_illegal;
    logic [1:0] b_alusrcb, b_pcsrc;
    logic [2:0] b_aluc;
    logic [3:0] b_state;

    logic       h_mem_req, h_iord, h_memwrite, h_irwrite, h_regdst, h_memtoreg, h_regwrite, h_alusrca, h_pcen, h_illegal;
    logic [1:0] h_alusrcb, h_pcsrc;
    logic [2:0] h_aluc;
    logic [3:0] h_state;

    always #5 clk = ~clk;

    mc_controller u_main (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero), .mem_ready(mr),
        .mem_req(m_mem_req), .iord(m_iord), .memwrite(m_memwrite), .irwrite(m_irwrite),
        .regdst(m_regdst), .memtoreg(m_memtoreg), .regwrite(m_regwrite), .alusrca(m_alusrca),
        .alusrcb(m_alusrcb), .pcsrc(m_pcsrc), .pcen(m_pcen), .alucontrol(m_aluc),
        .illegal(m_illegal), .state(m_state)
    );

    mc_controller #(.ENABLE_BNE(0)) u_nobne (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero), .mem_ready(mr),
        .mem_req(b_mem_req), .iord(b_iord), .memwrite(b_memwrite), .irwrite(b_irwrite),
        .regdst(b_regdst), .memtoreg(b_memtoreg), .regwrite(b_regwrite), .alusrca(b_alusrca),
        .alusrcb(b_alusrcb), .pcsrc(b_pcsrc), .pcen(b_pcen), .alucontrol(b_aluc),
        .illegal(b_illegal), .state(b_state)
    );

    mc_controller #(.MEM_HANDSHAKE(0)) u_nohs (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero), .mem_ready(1'b0),
        .mem_req(h_mem_req), .iord(h_iord), .memwrite(h_memwrite), .irwrite(h_irwrite),
        .regdst(h_regdst), .memtoreg(h_memtoreg), .regwrite(h_regwrite), .alusrca(h_alusrca),
        .alusrcb(h_alusrcb), .pcsrc(h_pcsrc), .pcen(h_pcen), .alucontrol(h_aluc),
        .illegal(h_illegal), .state(h_state)
    );

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pulse reset for one cycle; returns aligned to a falling edge.
    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; opcode = 6'b100011; funct = 6'b100000; zero = 1'b0; mr = 1'b1;
        #1;
        chk("rst_state",   m_state, 4'd0);
        chk("rst_mem_req", {3'b0, m_mem_req}, 4'd0);
        chk("rst_irwrite", {3'b0, m_irwrite}, 4'd0);
        chk("rst_pcen",    {3'b0, m_pcen}, 4'd0);
        chk("rst_alusrcb", {2'b0, m_alusrcb}, 4'd1);
        @(negedge clk);
        reset = 1'b0;

        // lw: 2 fetch waits, 3 read waits -> 0,0,0,1,2,3,3,3,3,4,0
        mr = 1'b0; #1;
        chk("lw_f0_state", m_state, 4'd0);
        chk("lw_f0_memreq", {3'b0, m_mem_req}, 4'd1);
        chk("lw_f0_irwrite", {3'b0, m_irwrite}, 4'd0);
        @(negedge clk);
        mr = 1'b0; #1;
        chk("lw_f1_state", m_state, 4'd0);
        @(negedge clk);
        mr = 1'b1; #1;
        chk("lw_f2_state", m_state, 4'd0);
        chk("lw_f2_irwrite", {3'b0, m_irwrite}, 4'd1);
        chk("lw_f2_pcen", {3'b0, m_pcen}, 4'd1);
        @(negedge clk); #1;
        chk("lw_dec_state", m_state, 4'd1);
        chk("lw_dec_alusrcb", {2'b0, m_alusrcb}, 4'd3);
        @(negedge clk); #1;
        chk("lw_adr_state", m_state, 4'd2);
        chk("lw_adr_alusrcb", {2'b0, m_alusrcb}, 4'd2);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            mr = 1'b0; #1;
            chk("lw_rdwait_state", m_state, 4'd3);
            chk("lw_rdwait_iord", {3'b0, m_iord}, 4'd1);
            chk("lw_rdwait_regwrite", {3'b0, m_regwrite}, 4'd0);
            @(negedge clk);
        end
        mr = 1'b1; #1;
        chk("lw_rd_state", m_state, 4'd3);
        @(negedge clk); #1;
        chk("lw_wb_state", m_state, 4'd4);
        chk("lw_wb_regwrite", {3'b0, m_regwrite}, 4'd1);
        chk("lw_wb_memtoreg", {3'b0, m_memtoreg}, 4'd1);
        @(negedge clk); #1;
        chk("lw_end_state", m_state, 4'd0);
        chk("lw_end_regwrite", {3'b0, m_regwrite}, 4'd0);

        // reset while waiting in MEMWR
        do_reset();
        opcode = 6'b101011; mr = 1'b1;
        @(negedge clk); @(negedge clk); @(negedge clk);
        mr = 1'b0; #1;
        chk("swr_wait_state", m_state, 4'd5);
        chk("swr_wait_memwrite", {3'b0, m_memwrite}, 4'd0);
        reset = 1'b1; #1;
        chk("swr_async_state", m_state, 4'd0);
        chk("swr_async_memwrite", {3'b0, m_memwrite}, 4'd0);
        chk("swr_async_pcen", {3'b0, m_pcen}, 4'd0);
        @(negedge clk); #1;
        chk("swr_held_pcen", {3'b0, m_pcen}, 4'd0);
        chk("swr_held_memreq", {3'b0, m_mem_req}, 4'd0);
        @(negedge clk);
        reset = 1'b0; mr = 1'b1;

        // R-type sub
        opcode = 6'b000000; funct = 6'b100010; #1;
        chk("r_f_state", m_state, 4'd0);
        @(negedge clk); #1;
        chk("r_d_state", m_state, 4'd1);
        @(negedge clk); #1;
        chk("r_ex_state", m_state, 4'd6);
        chk("r_ex_aluc", {1'b0, m_aluc}, 4'd6);
        chk("r_ex_alusrca", {3'b0, m_alusrca}, 4'd1);
        chk("r_ex_illegal", {3'b0, m_illegal}, 4'd0);
        funct = 6'b100101; #1;
        chk("r_ex_or_aluc", {1'b0, m_aluc}, 4'd1);
        funct = 6'b111111; #1;
        chk("r_ex_bad_aluc", {1'b0, m_aluc}, 4'd2);
        chk("r_ex_bad_illegal", {3'b0, m_illegal}, 4'd1);
        funct = 6'b100010;
        @(negedge clk); #1;
        chk("r_wb_state", m_state, 4'd7);
        chk("r_wb_regwrite", {3'b0, m_regwrite}, 4'd1);
        chk("r_wb_regdst", {3'b0, m_regdst}, 4'd1);
        @(negedge clk); #1;
        chk("r_end_state", m_state, 4'd0);

        // beq taken
        do_reset();
        opcode = 6'b000100; zero = 1'b1;
        @(negedge clk); @(negedge clk); #1;
        chk("beq_state", m_state, 4'd8);
        chk("beq_pcen", {3'b0, m_pcen}, 4'd1);
        chk("beq_pcsrc", {2'b0, m_pcsrc}, 4'd1);
        chk("beq_aluc", {1'b0, m_aluc}, 4'd6);
        @(negedge clk); #1;
        chk("beq_end_state", m_state, 4'd0);

        // bne with zero=1: not taken; disabled build flags illegal
        do_reset();
        opcode = 6'b000101; zero = 1'b1;
        @(negedge clk); #1;
        chk("bnedis_dec_state", b_state, 4'd1);
        chk("bnedis_dec_illegal", {3'b0, b_illegal}, 4'd1);
        chk("bne_dec_illegal", {3'b0, m_illegal}, 4'd0);
        @(negedge clk); #1;
        chk("bne_state", m_state, 4'd8);
        chk("bne_pcen", {3'b0, m_pcen}, 4'd0);
        chk("bnedis_next_state", b_state, 4'd0);
        zero = 1'b0; #1;
        chk("bne_nz_pcen", {3'b0, m_pcen}, 4'd1);

        // undefined opcode
        do_reset();
        opcode = 6'b111111;
        @(negedge clk); #1;
        chk("ill_dec_state", m_state, 4'd1);
        chk("ill_dec_illegal", {3'b0, m_illegal}, 4'd1);
        chk("ill_dec_regwrite", {3'b0, m_regwrite}, 4'd0);
        chk("ill_dec_memwrite", {3'b0, m_memwrite}, 4'd0);
        chk("ill_dec_pcen", {3'b0, m_pcen}, 4'd0);
        @(negedge clk); #1;
        chk("ill_next_state", m_state, 4'd0);
        chk("ill_next_illegal", {3'b0, m_illegal}, 4'd0);

        // addi
        do_reset();
        opcode = 6'b001000;
        @(negedge clk); @(negedge clk); #1;
        chk("addi_ex_state", m_state, 4'd9);
        chk("addi_ex_alusrcb", {2'b0, m_alusrcb}, 4'd2);
        @(negedge clk); #1;
        chk("addi_wb_state", m_state, 4'd10);
        chk("addi_wb_regwrite", {3'b0, m_regwrite}, 4'd1);
        chk("addi_wb_regdst", {3'b0, m_regdst}, 4'd0);

        // j
        do_reset();
        opcode = 6'b000010;
        @(negedge clk); @(negedge clk); #1;
        chk("j_state", m_state, 4'd11);
        chk("j_pcsrc", {2'b0, m_pcsrc}, 4'd2);
        chk("j_pcen", {3'b0, m_pcen}, 4'd1);

        // sw on the handshake-disabled build, mem_ready tied low
        do_reset();
        opcode = 6'b101011; mr = 1'b0; #1;
        chk("nohs_f_state", h_state, 4'd0);
        chk("nohs_f_irwrite", {3'b0, h_irwrite}, 4'd1);
        @(negedge clk); #1;
        chk("nohs_d_state", h_state, 4'd1);
        @(negedge clk); #1;
        chk("nohs_a_state", h_state, 4'd2);
        @(negedge clk); #1;
        chk("nohs_w_state", h_state, 4'd5);
        chk("nohs_w_memwrite", {3'b0, h_memwrite}, 4'd1);
        @(negedge clk); #1;
        chk("nohs_end_state", h_state, 4'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mc_controller.md
# mc_controller

Multicycle control unit for the MIPS datapath: a Moore state machine that sequences instruction fetch, decode, execute, memory and writeback over several cycles of one shared ALU and one shared memory. It generalises the single-cycle controller with:
- a variable-latency memory handshake;
- `bne` and `addi` support;
- an illegal-opcode flag;
- per-state enable gating, so the datapath needs no extra adders.

## Interface
Parameters:
- `MEM_HANDSHAKE`, default 1. 1 = memory states wait on `mem_ready`; 0 = `mem_ready` is ignored and treated as constant 1.
- `ENABLE_BNE`, default 1. 1 = opcode 000101 (`bne`) is legal; 0 = it is illegal.

Ports:
- `clk`  input  1  rising-edge clock
- `reset`  input  1  asynchronous, active-high reset
- `opcode`  input  6  instruction register [31:26]
- `funct`  input  6  instruction register [5:0]
- `zero`  input  1  ALU zero flag, combinational from the current-cycle ALU result
- `mem_ready`  input  1  memory completes the access this cycle
- `mem_req`  output  1  memory access requested this cycle
- `iord`  output  1  memory address select: 0 = PC, 1 = ALUOut
- `memwrite`  output  1  memory write strobe
- `irwrite`  output  1  instruction register load
- `regdst`  output  1  register-file write address: 0 = rt, 1 = rd
- `memtoreg`  output  1  register-file write data: 0 = ALUOut, 1 = MDR
- `regwrite`  output  1  register-file write enable
- `alusrca`  output  1  ALU A input: 0 = PC, 1 = register A
- `alusrcb`  output  2  ALU B input: 00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2
- `pcsrc`  output  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target
- `pcen`  output  1  PC load enable, with branch condition already applied
- `alucontrol`  output  3  ALU operation code
- `illegal`  output  1  one-cycle pulse on an undecodable opcode
- `state`  output  4  current state encoding, for debug

## Operation
State encodings:
- 0 `FETCH`, 1 `DECODE`, 2 `MEMADR`, 3 `MEMRD`, 4 `MEMWB`, 5 `MEMWR`
- 6 `EXEC`, 7 `ALUWB`, 8 `BRANCH`, 9 `ADDIEX`, 10 `ADDIWB`, 11 `JUMP`
- 12–15 unused; any of them returns to `FETCH` on the next clock.

Transitions:
- `FETCH` → `DECODE` on the cycle `mem_ready` = 1; otherwise stay in `FETCH`.
- `DECODE`, by opcode:
  - `lw` (100011) or `sw` (101011) → `MEMADR`
  - R-type (000000) → `EXEC`
  - `beq` (000100), or `bne` (000101) when `ENABLE_BNE` = 1 → `BRANCH`
  - `addi` (001000) → `ADDIEX`
  - `j` (000010) → `JUMP`
  - any other opcode → `FETCH`, with `illegal` = 1 for that cycle
- `MEMADR` → `MEMRD` for `lw`, → `MEMWR` for `sw`.
- `MEMRD` → `MEMWB` on `mem_ready`; otherwise stay.
- `MEMWR` → `FETCH` on `mem_ready`; otherwise stay.
- `EXEC` → `ALUWB`; `ADDIEX` → `ADDIWB`.
- `MEMWB`, `ALUWB`, `ADDIWB`, `BRANCH` and `JUMP` → `FETCH`.

Outputs by state (any output not listed is 0; `alucontrol` is add = 010 unless stated):
- `FETCH`: `mem_req` = 1; `alusrcb` = 01; `irwrite` = `pcen` = `mem_ready`.
- `DECODE`: `alusrcb` = 11 (branch target is computed into ALUOut).
- `MEMADR` and `ADDIEX`: `alusrca` = 1; `alusrcb` = 10.
- `MEMRD`: `mem_req` = 1; `iord` = 1.
- `MEMWR`: `mem_req` = 1; `iord` = 1; `memwrite` = `mem_ready`.
- `MEMWB`: `regwrite` = 1; `memtoreg` = 1.
- `EXEC`: `alusrca` = 1; `alucontrol` decoded from `funct`:
  - 100000 → 010 (add); 100010 → 110 (sub); 100100 → 000 (and); 100101 → 001 (or); 101010 → 111 (slt)
  - any other `funct` → 010, and `illegal` pulses in `EXEC`
- `ALUWB`: `regwrite` = 1; `regdst` = 1.
- `ADDIWB`: `regwrite` = 1.
- `BRANCH`:
  - `alusrca` = 1; `alucontrol` = 110 (sub); `pcsrc` = 01
  - `pcen` = `zero` for `beq`; `pcen` = !`zero` for `bne`
- `JUMP`: `pcsrc` = 10; `pcen` = 1.

Handshake rules:
- `memwrite` is high only on the completing cycle.
- The address select `iord` is held for every wait cycle.

## Timing
- Reset: asynchronous; `state` = `FETCH` immediately on assertion.
- While `reset` = 1, `pcen`, `irwrite`, `regwrite`, `memwrite`, `mem_req` and `illegal` are all forced to 0. Other outputs take their `FETCH` values.
- Reset mid-instruction abandons the instruction; no write enable is asserted after reset assertion.
- Cycles per instruction with zero wait: `lw` 5, `sw` 4, R-type 4, `addi` 4, `beq`/`bne` 3, `j` 3, illegal 2.
- Each cycle with `mem_ready` = 0 in a memory state adds exactly 1 cycle.
- `opcode` and `funct` are sampled every cycle; the datapath holds them stable from `irwrite` until the next `FETCH`.

## Test plan
- Reset while in `MEMWR` with `mem_ready` = 0 → `state` = 0 asynchronously; `memwrite` = 0; no `pcen` pulse.
- `lw` with `mem_ready` low for 2 cycles in `FETCH` and 3 cycles in `MEMRD` → state sequence 0,0,0,1,2,3,3,3,3,4,0; `regwrite` = 1 and `memtoreg` = 1 only in state 4.
- R-type with `funct` = 100010 → `alucontrol` = 110 in `EXEC`; `regwrite` = 1 and `regdst` = 1 in `ALUWB`; 4 cycles total.
- `beq` with `zero` = 1 gives `pcen` = 1 in `BRANCH`; `bne` with `zero` = 1 gives `pcen` = 0; with `ENABLE_BNE` = 0, `bne` pulses `illegal` in `DECODE` and returns to `FETCH`.
- Opcode 111111 → `illegal` pulses 1 cycle in `DECODE`; next state `FETCH`; no `regwrite`, `memwrite` or `pcen` asserted.
- `MEM_HANDSHAKE` = 0 with `mem_ready` tied to 0 → `sw` completes in 4 cycles, with `memwrite` = 1 in state 5.
